// File: rtl/os_tx_scheduler.sv
// os_tx_scheduler
// ---------------------------------------------------------------------------
// Transmit-side ordered-set scheduler for an 8b/10b PIPE lane (32-bit words,
// first symbol in [31:24]). It shares one TX word stream between three
// sources: the periodic SKP timer, LTSSM TS1/TS2 burst requests, and
// EIOS/EIEOS requests. Each ordered set is emitted whole. Arbitration only
// happens at ordered-set boundaries.
//
// Optional feature macro: OS_TX_SCHED_EIEOS_EN
//   defined     -> EIEOS requests are honoured. Priority is EIOS, SKP, EIEOS,
//                  TS, then idle.
//   not defined -> eieos_req_i is ignored. Priority is EIOS, SKP, TS, then
//                  idle.
//
// Parameters
//   SKP_INTERVAL   cycles between SKP schedules
//   SKP_PEND_MAX   saturation value of the pending-SKP counter
//
// Ports
//   clk_i, rst_n_i         clock, asynchronous active-low reset
//   ts_req_i               TS burst request pulse
//   ts_type_i              0 = TS1, 1 = TS2 (latched with ts_req_i)
//   ts_count_i             TSes in the burst (0 behaves as 1)
//   link_num_i .. symbol6_i TS fields, sampled at the first word of each TS
//   eios_req_i             send one EIOS, then enter electrical idle
//   eidle_exit_i           leave electrical idle
//   eieos_req_i            send one EIEOS
//   data_o, datak_o        TX word and per-byte K flags
//   data_valid_o           word valid
//   data_ready_i           PIPE accepts the word
//   tx_elec_idle_o         TX electrical idle
//   ts_busy_o              TS burst latched or in progress
//   ts_done_o              pulse after the last word of a burst is accepted
// ---------------------------------------------------------------------------
module os_tx_scheduler #(
    parameter int unsigned SKP_INTERVAL = 1180,
    parameter int unsigned SKP_PEND_MAX = 3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ts_req_i,
    input  logic        ts_type_i,
    input  logic [7:0]  ts_count_i,
    input  logic [7:0]  link_num_i,
    input  logic [7:0]  lane_num_i,
    input  logic [7:0]  nfts_i,
    input  logic [7:0]  rate_id_i,
    input  logic [7:0]  train_ctrl_i,
    input  logic [7:0]  symbol6_i,
    input  logic        eios_req_i,
    input  logic        eidle_exit_i,
    input  logic        eieos_req_i,
    output logic [31:0] data_o,
    output logic [3:0]  datak_o,
    output logic        data_valid_o,
    input  logic        data_ready_i,
    output logic        tx_elec_idle_o,
    output logic        ts_busy_o,
    output logic        ts_done_o
);

    localparam int unsigned TW = $clog2(SKP_INTERVAL);
    localparam int unsigned PW = $clog2(SKP_PEND_MAX + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SKP_INTERVAL - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [PW-1:0] PEND_MAX   = PW'(SKP_PEND_MAX);
    localparam logic [PW-1:0] PEND_ONE   = PW'(1);

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_IDL = 8'h7C;
    localparam logic [7:0] SYM_EIE = 8'hFC;
    localparam logic [7:0] SYM_PAD = 8'hF7;
    localparam logic [7:0] ID_TS1  = 8'h4A;
    localparam logic [7:0] ID_TS2  = 8'h45;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TS    = 3'd1,
        ST_SKP   = 3'd2,
        ST_EIOS  = 3'd3,
        ST_EIDLE = 3'd4
`ifdef OS_TX_SCHED_EIEOS_EN
        , ST_EIEOS = 3'd5
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   data_q, data_d;
    logic [3:0]    datak_q, datak_d;
    logic          valid_q, valid_d;
    logic          elec_idle_q, elec_idle_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [7:0]    rem_q, rem_d;
    logic          ts_type_q, ts_type_d;
    logic [7:0]    rate_q, rate_d;
    logic [7:0]    train_q, train_d;
    logic [7:0]    sym6_q, sym6_d;
    logic          eios_pend_q, eios_pend_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] pend_q, pend_d;

    logic          accept;
    logic          last_word;
    logic          load;
    logic          skp_take;
    logic          wrap;
    logic          ts_want;
    logic [7:0]    rem_after;
    logic [7:0]    count_eff;
    logic [7:0]    ts_id;
    logic          eieos_want;

`ifdef OS_TX_SCHED_EIEOS_EN
    logic          eieos_pend_q, eieos_pend_d;
    assign eieos_want = eieos_pend_q | eieos_req_i;
`else
    logic          eieos_req_unused;
    assign eieos_req_unused = eieos_req_i;
    assign eieos_want       = 1'b0;
`endif

    assign accept    = valid_q & data_ready_i;
    assign count_eff = (ts_count_i == 8'd0) ? 8'd1 : ts_count_i;

    // Main sequencer: burst bookkeeping, boundary arbitration, word building.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        data_d      = data_q;
        datak_d     = datak_q;
        valid_d     = valid_q;
        elec_idle_d = elec_idle_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rem_d       = rem_q;
        ts_type_d   = ts_type_q;
        rate_d      = rate_q;
        train_d     = train_q;
        sym6_d      = sym6_q;
        eios_pend_d = eios_pend_q | eios_req_i;
`ifdef OS_TX_SCHED_EIEOS_EN
        eieos_pend_d = eieos_pend_q | eieos_req_i;
`endif
        load      = 1'b0;
        skp_take  = 1'b0;
        rem_after = rem_q;
        ts_id     = ID_TS1;

        case (state_q)
            ST_TS:    last_word = (idx_q == 2'd3);
`ifdef OS_TX_SCHED_EIEOS_EN
            ST_EIEOS: last_word = (idx_q == 2'd3);
`endif
            default:  last_word = 1'b1;
        endcase

        // Retiring the last word of a TS decrements the remaining count.
        if (state_q == ST_TS && idx_q == 2'd3 && accept) begin
            rem_after = rem_q - 8'd1;
            rem_d     = rem_after;
            if (rem_after == 8'd0) begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
        end

        if (ts_req_i && !busy_q) begin
            busy_d    = 1'b1;
            rem_d     = count_eff;
            ts_type_d = ts_type_i;
        end

        // A brand-new request can start at this same boundary.
        ts_want = (ts_req_i && !busy_q) || (busy_q && rem_after != 8'd0);

        case (state_q)
            ST_EIDLE: begin
                valid_d     = 1'b0;
                elec_idle_d = 1'b1;
                data_d      = 32'h0;
                datak_d     = 4'h0;
                if (eidle_exit_i) begin
                    state_d     = ST_IDLE;
                    valid_d     = 1'b1;
                    elec_idle_d = 1'b0;
                end
            end
            ST_EIOS: begin
                if (accept) begin
                    state_d     = ST_EIDLE;
                    valid_d     = 1'b0;
                    elec_idle_d = 1'b1;
                    data_d      = 32'h0;
                    datak_d     = 4'h0;
                end
            end
            default: begin
                // Invalid idle only occurs on the first cycle after reset.
                if ((state_q == ST_IDLE && !valid_q) || (accept && last_word)) begin
                    load        = 1'b1;
                    idx_d       = 2'd0;
                    valid_d     = 1'b1;
                    elec_idle_d = 1'b0;
                    if (eios_pend_q || eios_req_i) begin
                        state_d     = ST_EIOS;
                        eios_pend_d = eios_pend_q & eios_req_i;
                        busy_d      = 1'b0;
                        rem_d       = 8'd0;
                    end else if (pend_q != '0) begin
                        state_d  = ST_SKP;
                        skp_take = 1'b1;
`ifdef OS_TX_SCHED_EIEOS_EN
                    end else if (eieos_want) begin
                        state_d      = ST_EIEOS;
                        eieos_pend_d = eieos_pend_q & eieos_req_i;
`endif
                    end else if (ts_want) begin
                        state_d = ST_TS;
                        rate_d  = rate_id_i;
                        train_d = train_ctrl_i;
                        sym6_d  = symbol6_i;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (accept) begin
                    load  = 1'b1;
                    idx_d = idx_q + 2'd1;
                end
            end
        endcase

        if (load) begin
            ts_id = ts_type_d ? ID_TS2 : ID_TS1;
            case (state_d)
                ST_TS: begin
                    case (idx_d)
                        2'd0: begin
                            data_d  = {SYM_COM, link_num_i, lane_num_i, nfts_i};
                            datak_d = {1'b1, link_num_i == SYM_PAD, lane_num_i == SYM_PAD, 1'b0};
                        end
                        2'd1: begin
                            data_d  = {rate_d, train_d, sym6_d, ts_id};
                            datak_d = 4'b0000;
                        end
                        default: begin
                            data_d  = {4{ts_id}};
                            datak_d = 4'b0000;
                        end
                    endcase
                end
                ST_SKP: begin
                    data_d  = {SYM_COM, SYM_SKP, SYM_SKP, SYM_SKP};
                    datak_d = 4'b1111;
                end
                ST_EIOS: begin
                    data_d  = {SYM_COM, SYM_IDL, SYM_IDL, SYM_IDL};
                    datak_d = 4'b1111;
                end
`ifdef OS_TX_SCHED_EIEOS_EN
                ST_EIEOS: begin
                    case (idx_d)
                        2'd0: begin
                            data_d  = {SYM_COM, SYM_EIE, SYM_EIE, SYM_EIE};
                            datak_d = 4'b1111;
                        end
                        2'd3: begin
                            data_d  = {SYM_EIE, SYM_EIE, SYM_EIE, ID_TS1};
                            datak_d = 4'b1110;
                        end
                        default: begin
                            data_d  = {4{SYM_EIE}};
                            datak_d = 4'b1111;
                        end
                    endcase
                end
`endif
                default: begin
                    data_d  = 32'h0;
                    datak_d = 4'h0;
                end
            endcase
        end
    end

    // SKP timer and pending count. Both are frozen at zero in electrical idle.
    // A wrap and a transmitted SKP in the same cycle cancel out.
    always_comb begin
        timer_d = timer_q;
        pend_d  = pend_q;
        wrap    = 1'b0;
        if (state_q == ST_EIDLE) begin
            timer_d = '0;
            pend_d  = '0;
        end else begin
            wrap    = (timer_q == TIMER_LAST);
            timer_d = wrap ? '0 : timer_q + TIMER_ONE;
            if (wrap && !skp_take) begin
                if (pend_q != PEND_MAX) begin
                    pend_d = pend_q + PEND_ONE;
                end
            end else if (!wrap && skp_take) begin
                pend_d = pend_q - PEND_ONE;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            data_q      <= 32'h0;
            datak_q     <= 4'h0;
            valid_q     <= 1'b0;
            elec_idle_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rem_q       <= 8'd0;
            ts_type_q   <= 1'b0;
            rate_q      <= 8'd0;
            train_q     <= 8'd0;
            sym6_q      <= 8'd0;
            eios_pend_q <= 1'b0;
            timer_q     <= '0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            datak_q     <= datak_d;
            valid_q     <= valid_d;
            elec_idle_q <= elec_idle_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rem_q       <= rem_d;
            ts_type_q   <= ts_type_d;
            rate_q      <= rate_d;
            train_q     <= train_d;
            sym6_q      <= sym6_d;
            eios_pend_q <= eios_pend_d;
            timer_q     <= timer_d;
            pend_q      <= pend_d;
        end
    end

`ifdef OS_TX_SCHED_EIEOS_EN
    // EIEOS request flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            eieos_pend_q <= 1'b0;
        end else begin
            eieos_pend_q <= eieos_pend_d;
        end
    end
`endif

    assign data_o         = data_q;
    assign datak_o        = datak_q;
    assign data_valid_o   = valid_q;
    assign tx_elec_idle_o = elec_idle_q;
    assign ts_busy_o      = busy_q;
    assign ts_done_o      = done_q;

endmodule

// File: tb/tb_os_tx_scheduler.sv
// tb_os_tx_scheduler
// ---------------------------------------------------------------------------
// Directed bench for os_tx_scheduler, built with SKP_INTERVAL = 16.
// Every scenario starts from a fresh reset, so the SKP timer phase is known.
// "E<n>" in comments means the n-th rising edge after reset release.
// ---------------------------------------------------------------------------
module tb_os_tx_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        ts_req_i = 1'b0;
    logic        ts_type_i = 1'b0;
    logic [7:0]  ts_count_i = 8'd0;
    logic [7:0]  link_num_i = 8'd0;
    logic [7:0]  lane_num_i = 8'd0;
    logic [7:0]  nfts_i = 8'd0;
    logic [7:0]  rate_id_i = 8'd0;
    logic [7:0]  train_ctrl_i = 8'd0;
    logic [7:0]  symbol6_i = 8'd0;
    logic        eios_req_i = 1'b0;
    logic        eidle_exit_i = 1'b0;
    logic        eieos_req_i = 1'b0;
    logic [31:0] data_o;
    logic [3:0]  datak_o;
    logic        data_valid_o;
    logic        data_ready_i = 1'b1;
    logic        tx_elec_idle_o;
    logic        ts_busy_o;
    logic        ts_done_o;

    int compareCount = 0;
    int failCount = 0;
    int doneCount = 0;
    int acceptCount = 0;
    int skpCount = 0;

    os_tx_scheduler #(
        .SKP_INTERVAL(16),
        .SKP_PEND_MAX(3)
    ) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .ts_req_i(ts_req_i),
        .ts_type_i(ts_type_i),
        .ts_count_i(ts_count_i),
        .link_num_i(link_num_i),
        .lane_num_i(lane_num_i),
        .nfts_i(nfts_i),
        .rate_id_i(rate_id_i),
        .train_ctrl_i(train_ctrl_i),
        .symbol6_i(symbol6_i),
        .eios_req_i(eios_req_i),
        .eidle_exit_i(eidle_exit_i),
        .eieos_req_i(eieos_req_i),
        .data_o(data_o),
        .datak_o(datak_o),
        .data_valid_o(data_valid_o),
        .data_ready_i(data_ready_i),
        .tx_elec_idle_o(tx_elec_idle_o),
        .ts_busy_o(ts_busy_o),
        .ts_done_o(ts_done_o)
    );

    // 10 ns clock.
    always #5 clk_i = ~clk_i;

    // Passive monitor on the falling edge: done pulses, accepted words, SKPs.
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (ts_done_o) doneCount++;
            if (data_valid_o && data_ready_i) begin
                acceptCount++;
                if (data_o == 32'hBC1C1C1C && datak_o == 4'hF) skpCount++;
            end
        end
    end

    // Hard stop in case anything stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Valid word with the given data and K flags.
    task automatic checkWord(input string tag, input logic [31:0] d, input logic [3:0] k);
        checkOutput(tag, {27'd0, data_valid_o, datak_o, data_o}, {27'd0, 1'b1, k, d});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic applyStimulus(input logic req, input logic typ, input logic [7:0] cnt,
                                 input logic [7:0] lnk, input logic [7:0] lan,
                                 input logic [7:0] nft, input logic [7:0] rate,
                                 input logic [7:0] trn, input logic [7:0] s6);
        ts_req_i     = req;
        ts_type_i    = typ;
        ts_count_i   = cnt;
        link_num_i   = lnk;
        lane_num_i   = lan;
        nfts_i       = nft;
        rate_id_i    = rate;
        train_ctrl_i = trn;
        symbol6_i    = s6;
    endtask

    // Leaves the bench 2 ns after the edge where reset was released.
    task automatic applyReset(input logic readyVal);
        rst_n_i      = 1'b0;
        ts_req_i     = 1'b0;
        eios_req_i   = 1'b0;
        eieos_req_i  = 1'b0;
        eidle_exit_i = 1'b0;
        data_ready_i = readyVal;
        tick(2);
        rst_n_i = 1'b1;
    endtask

    logic [31:0] bpData [9];
    logic [3:0]  bpK [9];
    logic        bpReady [9];
    int          doneBase;
    int          accBase;
    int          skpBase;

    initial begin
        $display("[TB] start");

        // ---------------- Reset values ----------------
        #12;
        checkOutput("reset_outputs",
                    {26'd0, data_valid_o, tx_elec_idle_o, ts_busy_o, ts_done_o, datak_o, data_o},
                    64'd0);

        // ---------------- Single TS1 ----------------
        applyReset(1'b1);
        tick(1);                                           // E1
        checkOutput("first_idle", {27'd0, data_valid_o, tx_elec_idle_o, datak_o, data_o},
                    {27'd0, 1'b1, 1'b0, 4'h0, 32'h0});
        applyStimulus(1'b1, 1'b0, 8'd1, 8'h01, 8'hF7, 8'h10, 8'h06, 8'h08, 8'h55);
        tick(1);                                           // E2
        ts_req_i = 1'b0;
        checkWord("ts1_w0", 32'hBC01F710, 4'b1010);
        checkOutput("ts1_busy_rise", ts_busy_o, 1);
        tick(1);
        checkWord("ts1_w1", 32'h0608554A, 4'b0000);
        tick(1);
        checkWord("ts1_w2", 32'h4A4A4A4A, 4'b0000);
        tick(1);
        checkWord("ts1_w3", 32'h4A4A4A4A, 4'b0000);
        checkOutput("ts1_done_early", ts_done_o, 0);
        tick(1);                                           // E6
        checkWord("ts1_idle_after", 32'h0, 4'h0);
        checkOutput("ts1_done", {ts_done_o, ts_busy_o}, 2'b10);
        tick(1);
        checkOutput("ts1_done_one_cycle", ts_done_o, 0);

        // ---------------- Backpressure on a TS2 (count 0 -> 1) ----------------
        applyReset(1'b1);
        tick(1);                                           // E1
        data_ready_i = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'd0, 8'hF7, 8'hF7, 8'h20, 8'h02, 8'h01, 8'h33);
        tick(1);                                           // E2: idle not accepted
        ts_req_i = 1'b0;
        checkWord("bp_idle_held", 32'h0, 4'h0);
        checkOutput("bp_busy", ts_busy_o, 1);
        bpReady = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bpData  = '{32'hBCF7F720, 32'hBCF7F720, 32'h02013345, 32'h02013345,
                    32'h45454545, 32'h45454545, 32'h45454545, 32'h45454545, 32'h0};
        bpK     = '{4'b1110, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                    4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 9; i++) begin
            data_ready_i = bpReady[i];
            tick(1);                                       // E3..E11
            checkWord($sformatf("bp_word%0d", i), bpData[i], bpK[i]);
            checkOutput($sformatf("bp_done%0d", i), ts_done_o, (i == 8) ? 1 : 0);
        end
        checkOutput("bp_busy_fall", ts_busy_o, 0);

        // ---------------- EIOS abort of a 4-TS burst ----------------
        applyReset(1'b1);
        tick(1);                                           // E1
        applyStimulus(1'b1, 1'b0, 8'd4, 8'h01, 8'h00, 8'h10, 8'h02, 8'h00, 8'h4A);
        tick(1);                                           // E2
        ts_req_i = 1'b0;
        doneBase = doneCount;
        checkWord("eios_ts1_w0", 32'hBC010010, 4'b1000);
        tick(4);                                           // E6
        checkWord("eios_ts2_w0", 32'hBC010010, 4'b1000);
        tick(1);                                           // E7
        checkWord("eios_ts2_w1", 32'h02004A4A, 4'b0000);
        eios_req_i = 1'b1;
        tick(1);                                           // E8
        eios_req_i = 1'b0;
        checkWord("eios_ts2_w2", 32'h4A4A4A4A, 4'b0000);
        tick(1);                                           // E9
        checkWord("eios_ts2_w3", 32'h4A4A4A4A, 4'b0000);
        tick(1);                                           // E10
        checkWord("eios_word", 32'hBC7C7C7C, 4'b1111);
        checkOutput("eios_busy_cleared", ts_busy_o, 0);
        tick(1);                                           // E11
        checkOutput("eidle_enter", {data_valid_o, tx_elec_idle_o}, 2'b01);
        tick(3);
        checkOutput("eidle_stay", {data_valid_o, tx_elec_idle_o}, 2'b01);
        eidle_exit_i = 1'b1;
        tick(1);
        eidle_exit_i = 1'b0;
        checkOutput("eidle_exit", {data_valid_o, tx_elec_idle_o, data_o}, {1'b1, 1'b0, 32'h0});
        tick(1);
        checkWord("eidle_idle_resume", 32'h0, 4'h0);
        checkOutput("eios_no_done", doneCount - doneBase, 0);

        // ---------------- SKP insertion in an 8-TS burst ----------------
        applyReset(1'b1);
        tick(1);                                           // E1
        accBase = acceptCount;
        skpBase = skpCount;
        doneBase = doneCount;
        applyStimulus(1'b1, 1'b0, 8'd8, 8'h01, 8'h02, 8'h03, 8'h02, 8'h00, 8'h4A);
        tick(1);                                           // E2
        ts_req_i = 1'b0;
        checkWord("skp_ts1_w0", 32'hBC010203, 4'b1000);
        tick(3);                                           // E5
        ts_req_i   = 1'b1;                                 // ignored while busy
        ts_type_i  = 1'b1;
        ts_count_i = 8'd2;
        tick(1);                                           // E6
        ts_req_i = 1'b0;
        tick(11);                                          // E17
        checkWord("skp_ts4_w3", 32'h4A4A4A4A, 4'b0000);
        tick(1);                                           // E18
        checkWord("skp_between", 32'hBC1C1C1C, 4'b1111);
        link_num_i = 8'h05;
        tick(1);                                           // E19
        checkWord("skp_ts5_w0", 32'hBC050203, 4'b1000);
        tick(15);                                          // E34
        checkWord("skp_ts8_w3", 32'h4A4A4A4A, 4'b0000);
        checkOutput("skp_busy_mid", ts_busy_o, 1);
        tick(1);                                           // E35
        checkWord("skp_after_burst", 32'hBC1C1C1C, 4'b1111);
        checkOutput("skp_burst_done", {ts_done_o, ts_busy_o}, 2'b10);
        tick(1);                                           // E36
        checkWord("skp_idle_after", 32'h0, 4'h0);
        checkOutput("skp_count", skpCount - skpBase, 2);
        checkOutput("skp_accepted_words", acceptCount - accBase, 35);
        checkOutput("skp_done_count", doneCount - doneBase, 1);

        // ---------------- Pending-SKP saturation under long stall ----------------
        applyReset(1'b0);
        tick(1);                                           // E1
        checkWord("sat_idle_stalled", 32'h0, 4'h0);
        tick(84);                                          // E85: five wraps seen
        data_ready_i = 1'b1;
        skpBase = skpCount;
        tick(1);                                           // E86
        checkWord("sat_skp0", 32'hBC1C1C1C, 4'b1111);
        tick(2);                                           // E88
        checkWord("sat_skp2", 32'hBC1C1C1C, 4'b1111);
        tick(1);                                           // E89
        checkWord("sat_idle", 32'h0, 4'h0);
        tick(1);
        checkOutput("sat_skp_count", skpCount - skpBase, 3);

        // ---------------- EIEOS ----------------
        applyReset(1'b1);
        tick(1);                                           // E1
        eieos_req_i = 1'b1;
        tick(1);                                           // E2
        eieos_req_i = 1'b0;
`ifdef OS_TX_SCHED_EIEOS_EN
        checkWord("eieos_w0", 32'hBCFCFCFC, 4'b1111);
        tick(1);
        checkWord("eieos_w1", 32'hFCFCFCFC, 4'b1111);
        tick(1);
        checkWord("eieos_w2", 32'hFCFCFCFC, 4'b1111);
        tick(1);
        checkWord("eieos_w3", 32'hFCFCFC4A, 4'b1110);
`else
        checkWord("eieos_off_w0", 32'h0, 4'h0);
        tick(3);
        checkWord("eieos_off_w3", 32'h0, 4'h0);
`endif
        tick(1);                                           // E6
        checkWord("eieos_idle_after", 32'h0, 4'h0);

        // ---------------- Reset mid-EIEOS, then SKP timer restart ----------------
        eieos_req_i = 1'b1;
        tick(1);                                           // E7
        eieos_req_i = 1'b0;
        tick(1);                                           // E8
        rst_n_i = 1'b0;
        #1;
        checkOutput("reset_mid_set",
                    {26'd0, data_valid_o, tx_elec_idle_o, ts_busy_o, ts_done_o, datak_o, data_o},
                    64'd0);
        applyReset(1'b1);
        tick(1);                                           // E1
        checkWord("reset_first_idle", 32'h0, 4'h0);
        tick(15);                                          // E16
        checkWord("reset_no_skp_yet", 32'h0, 4'h0);
        tick(1);                                           // E17
        checkWord("reset_skp_restart", 32'hBC1C1C1C, 4'b1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
